// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: edge-latched interrupt arbiter with priority threshold and nesting stack.
module irq_prio_ctrl #(
  parameter int NUM_SRC    = 8,
  parameter int PRIO_W     = 3,
  parameter int NEST_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  output logic               irq,
  input  logic               irq_ack,
  input  logic               eret_ack,
  input  logic               reg_we,
  input  logic [2:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic [3:0]         claim_id,
  output logic               nest_err
);
  localparam int DW = $clog2(NEST_DEPTH + 1);
  localparam int AW = NEST_DEPTH > 1 ? $clog2(NEST_DEPTH) : 1;
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [NUM_SRC-1:0] pend_q, pend_d, en_q, en_d;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [NUM_SRC];
  logic [PRIO_W-1:0]  thr_q, thr_d, win_prio_q, win_prio_d;
  logic [PRIO_W-1:0]  stk_prio_q [NEST_DEPTH];
  logic [PRIO_W-1:0]  stk_prio_d [NEST_DEPTH];
  logic [2:0]         stk_id_q [NEST_DEPTH];
  logic [2:0]         stk_id_d [NEST_DEPTH];
  logic [2:0]         win_id_q, win_id_d, best_id;
  logic [DW-1:0]      depth_q, depth_d, mid;
  logic               irq_q, irq_d, err_q, err_d;
  logic [NUM_SRC-1:0] rise, sw_clr, ack_clr;
  logic [PRIO_W-1:0]  act_prio, floor_prio, best_prio;
  logic [AW-1:0]      top;
  logic [31:0]        prio_rd;
  logic               empty, full, push, pop, go;
  logic               unused_wdata;
  assign unused_wdata = ^reg_wdata;
  assign empty      = depth_q == '0;
  assign full       = depth_q == DW'(NEST_DEPTH);
  assign top        = AW'(depth_q - DW'(1));
  assign act_prio   = empty ? '0 : stk_prio_q[top];
  assign floor_prio = thr_q > act_prio ? thr_q : act_prio;
  assign irq        = irq_q;
  assign nest_err   = err_q;
  assign claim_id   = empty ? 4'h0 : {1'b1, stk_id_q[top]};
  // Strict compare keeps the lowest index on equal priorities; any winner has prio > 0.
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    prio_rd   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pend_q[i] && en_q[i] && prio_q[i] > floor_prio && prio_q[i] > best_prio) begin
        best_prio = prio_q[i];
        best_id   = 3'(i);
      end
      prio_rd[4*i +: PRIO_W] = prio_q[i];
    end
  end
  always_comb begin
    sync1_d    = src_irq;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    rise       = sync2_q & ~prev_q;
    push       = state_q == REQ && irq_ack;
    pop        = eret_ack && !empty;
    go         = best_prio != '0 && !full;
    sw_clr     = reg_we && reg_addr == 3'd0 ? reg_wdata[NUM_SRC-1:0] : '0;
    ack_clr    = push ? NUM_SRC'(1) << win_id_q : '0;
    pend_d     = (pend_q & ~sw_clr & ~ack_clr) | rise;
    en_d       = reg_we && reg_addr == 3'd1 ? reg_wdata[NUM_SRC-1:0] : en_q;
    thr_d      = reg_we && reg_addr == 3'd3 ? reg_wdata[PRIO_W-1:0] : thr_q;
    for (int i = 0; i < NUM_SRC; i++)
      prio_d[i] = reg_we && reg_addr == 3'd2 ? reg_wdata[4*i +: PRIO_W] : prio_q[i];
    stk_prio_d = stk_prio_q;
    stk_id_d   = stk_id_q;
    mid        = depth_q - DW'(pop);
    if (push) begin
      stk_prio_d[AW'(mid)] = win_prio_q;
      stk_id_d[AW'(mid)]   = win_id_q;
    end
    depth_d    = mid + DW'(push);
    err_d      = (err_q & ~(reg_we && reg_addr == 3'd5 && reg_wdata[31]))
               | (eret_ack & empty) | (irq_ack && state_q == IDLE && full);
    state_d    = state_q == IDLE ? (go ? REQ : IDLE) : (irq_ack ? IDLE : REQ);
    win_id_d   = state_q == IDLE && go ? best_id : win_id_q;
    win_prio_d = state_q == IDLE && go ? best_prio : win_prio_q;
    irq_d      = state_d == REQ;
    reg_rdata  = reg_addr == 3'd0 ? 32'(pend_q) :
                 reg_addr == 3'd1 ? 32'(en_q) :
                 reg_addr == 3'd2 ? prio_rd :
                 reg_addr == 3'd3 ? 32'(thr_q) :
                 reg_addr == 3'd4 ? 32'(claim_id) :
                 reg_addr == 3'd5 ? {err_q, 31'(depth_q)} : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      pend_q     <= '0;
      en_q       <= '0;
      prio_q     <= '{default: '0};
      thr_q      <= '0;
      stk_prio_q <= '{default: '0};
      stk_id_q   <= '{default: '0};
      depth_q    <= '0;
      win_id_q   <= '0;
      win_prio_q <= '0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      prio_q     <= prio_d;
      thr_q      <= thr_d;
      stk_prio_q <= stk_prio_d;
      stk_id_q   <= stk_id_d;
      depth_q    <= depth_d;
      win_id_q   <= win_id_d;
      win_prio_q <= win_prio_d;
      irq_q      <= irq_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// tb_irq_prio_ctrl: table-driven directed vectors plus hand-written reset sequences.
module tb_irq_prio_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  src_irq = '0;
  logic        irq, irq_ack = 1'b0, eret_ack = 1'b0, reg_we = 1'b0, nest_err;
  logic [2:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0, reg_rdata;
  logic [3:0]  claim_id;
  int          errors = 0;
  int          checks = 0;

  irq_prio_ctrl dut (
    .clk(clk), .rst(rst), .src_irq(src_irq), .irq(irq), .irq_ack(irq_ack),
    .eret_ack(eret_ack), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .claim_id(claim_id), .nest_err(nest_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    string      name;
    bit         we;
    bit [2:0]   wa;
    bit [31:0]  wd;
    bit [7:0]   src;
    bit         ack;
    bit         eret;
    bit [2:0]   ra;
    bit         ei;
    bit [31:0]  er;
  } vec_t;
  vec_t vq[$];

  task automatic v(input string n, input bit we, input bit [2:0] wa, input bit [31:0] wd,
                   input bit [7:0] src, input bit ack, input bit eret, input bit [2:0] ra,
                   input bit ei, input bit [31:0] er);
    vq.push_back('{n, we, wa, wd, src, ack, eret, ra, ei, er});
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic wr(input bit [2:0] a, input bit [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  initial begin
    // single source
    v("en",       1,1,'h1,0,0,0,1,0,'h1);
    v("prio",     1,2,'h3,0,0,0,2,0,'h3);
    v("s0_e0",    0,0,0,1,0,0,0,0,0);
    v("s0_e1",    0,0,0,1,0,0,0,0,0);
    v("s0_pend",  0,0,0,0,0,0,0,0,1);
    v("s0_irq",   0,0,0,0,0,0,0,1,1);
    v("s0_ack",   0,0,0,0,1,0,4,0,'h8);
    v("s0_clr",   0,0,0,0,0,0,0,0,0);
    v("s0_dep",   0,0,0,0,0,0,5,0,1);
    v("s0_eret",  0,0,0,0,0,1,5,0,0);
    // priority and tie
    v("t_en",     1,1,'h64,0,0,0,1,0,'h64);
    v("t_prio",   1,2,'h02500503,0,0,0,2,0,'h02500503);
    v("t_e0",     0,0,0,'h64,0,0,0,0,0);
    v("t_e1",     0,0,0,'h64,0,0,0,0,0);
    v("t_pend",   0,0,0,0,0,0,0,0,'h64);
    v("t_irq",    0,0,0,0,0,0,4,1,0);
    v("t_ack2",   0,0,0,0,1,0,4,0,'hA);
    v("t_hold5",  0,0,0,0,0,0,0,0,'h60);
    v("t_hold5b", 0,0,0,0,0,0,5,0,1);
    v("t_eret",   0,0,0,0,0,1,5,0,0);
    v("t_irq5",   0,0,0,0,0,0,0,1,'h60);
    v("t_ack5",   0,0,0,0,1,0,4,0,'hD);
    v("t_hold6",  0,0,0,0,0,0,0,0,'h40);
    v("t_eret5",  0,0,0,0,0,1,5,0,0);
    v("t_irq6",   0,0,0,0,0,0,4,1,0);
    v("t_ack6",   0,0,0,0,1,0,4,0,'hE);
    // nesting on top of src6 (prio 2)
    v("n_en",     1,1,'h66,0,0,0,1,0,'h66);
    v("n_prio",   1,2,'h02500573,0,0,0,2,0,'h02500573);
    v("n_e0",     0,0,0,2,0,0,0,0,0);
    v("n_e1",     0,0,0,2,0,0,0,0,0);
    v("n_pend",   0,0,0,0,0,0,0,0,2);
    v("n_irq",    0,0,0,0,0,0,5,1,1);
    v("n_ack",    0,0,0,0,1,0,4,0,'h9);
    v("n_dep",    0,0,0,0,0,0,5,0,2);
    v("n_eret1",  0,0,0,0,0,1,4,0,'hE);
    v("n_eret2",  0,0,0,0,0,1,4,0,0);
    v("n_dep0",   0,0,0,0,0,0,5,0,0);
    // request frozen in REQ, survives a software clear
    v("f_en",     1,1,'h18,0,0,0,1,0,'h18);
    v("f_prio",   1,2,'h00062000,0,0,0,2,0,'h00062000);
    v("f_e3a",    0,0,0,'h08,0,0,0,0,0);
    v("f_e3b",    0,0,0,'h08,0,0,0,0,0);
    v("f_pend3",  0,0,0,0,0,0,0,0,'h08);
    v("f_irq3",   0,0,0,0,0,0,0,1,'h08);
    v("f_e4a",    0,0,0,'h10,0,0,0,1,'h08);
    v("f_swclr",  1,0,'h08,'h10,0,0,0,1,0);
    v("f_pend4",  0,0,0,0,0,0,0,1,'h10);
    v("f_ack3",   0,0,0,0,1,0,4,0,'hB);
    v("f_irq4",   0,0,0,0,0,0,0,1,'h10);
    v("f_ack4",   0,0,0,0,1,0,4,0,'hC);
    v("f_eret1",  0,0,0,0,0,1,4,0,'hB);
    v("f_eret2",  0,0,0,0,0,1,5,0,0);
    // boundaries
    v("b_eret_empty",0,0,0,0,0,1,5,0,'h80000000);
    v("b_err_clr",   1,5,'h80000000,0,0,0,5,0,0);
    v("b_ack_idle",  0,0,0,0,1,0,5,0,0);
    v("b_en0",       1,1,0,0,0,0,1,0,0);
    v("b_e0a",       0,0,0,1,0,0,0,0,0);
    v("b_e0b",       0,0,0,1,0,0,0,0,0);
    v("b_w1c_edge",  1,0,1,0,0,0,0,0,1);
    v("b_w1c",       1,0,1,0,0,0,0,0,0);
    v("b_prio_mask", 1,2,'hFFFFFFFF,0,0,0,2,0,'h77777777);
    v("b_thr",       1,3,'hFF,0,0,0,3,0,7);
    v("b_thr0",      1,3,0,0,0,0,3,0,0);
    v("b_unmapped",  1,6,'h1234,0,0,0,6,0,0);
    // fill the stack, then hit the full limit
    v("s_prio",   1,2,'h00054321,0,0,0,2,0,'h00054321);
    v("s_e0",     0,0,0,'h1F,0,0,0,0,0);
    v("s_e1",     0,0,0,'h1F,0,0,0,0,0);
    v("s_pend",   0,0,0,0,0,0,0,0,'h1F);
    v("s_en1",    1,1,'h01,0,0,0,0,0,'h1F);
    v("s_irq1",   0,0,0,0,0,0,0,1,'h1F);
    v("s_ack1",   0,0,0,0,1,0,5,0,1);
    v("s_en2",    1,1,'h03,0,0,0,0,0,'h1E);
    v("s_irq2",   0,0,0,0,0,0,0,1,'h1E);
    v("s_ack2",   0,0,0,0,1,0,5,0,2);
    v("s_en3",    1,1,'h07,0,0,0,0,0,'h1C);
    v("s_irq3",   0,0,0,0,0,0,0,1,'h1C);
    v("s_ack3",   0,0,0,0,1,0,5,0,3);
    v("s_en4",    1,1,'h0F,0,0,0,0,0,'h18);
    v("s_irq4",   0,0,0,0,0,0,0,1,'h18);
    v("s_ack4",   0,0,0,0,1,0,4,0,'hB);
    v("s_en5",    1,1,'h1F,0,0,0,5,0,4);
    v("s_full",   0,0,0,0,0,0,0,0,'h10);
    v("s_ack_full",0,0,0,0,1,0,5,0,'h80000004);
    v("s_eret",   0,0,0,0,0,1,5,0,'h80000003);
    v("s_irq5",   0,0,0,0,0,0,4,1,'hA);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_claim", 32'(claim_id), 0);
    chk("rst_err", 32'(nest_err), 0);
    for (int a = 0; a < 6; a++) begin
      reg_addr = 3'(a);
      #1;
      chk($sformatf("rst_reg%0d", a), reg_rdata, 0);
    end
    rst = 1'b1;

    foreach (vq[k]) begin
      reg_we = vq[k].we; reg_addr = vq[k].we ? vq[k].wa : vq[k].ra; reg_wdata = vq[k].wd;
      src_irq = vq[k].src; irq_ack = vq[k].ack; eret_ack = vq[k].eret;
      @(posedge clk); #1;
      reg_we = 1'b0; irq_ack = 1'b0; eret_ack = 1'b0; reg_addr = vq[k].ra;
      #1;
      chk({vq[k].name, "/irq"}, 32'(irq), 32'(vq[k].ei));
      chk({vq[k].name, "/rd"}, reg_rdata, vq[k].er);
    end

    // async reset while in REQ, observed before the next clock edge
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ar_irq", 32'(irq), 0);
    chk("ar_claim", 32'(claim_id), 0);
    chk("ar_err", 32'(nest_err), 0);
    for (int a = 0; a < 6; a++) begin
      reg_addr = 3'(a);
      #1;
      chk($sformatf("ar_reg%0d", a), reg_rdata, 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wr(3'd1, 32'h1F);
    wr(3'd2, 32'h00054321);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_irq%0d", c), 32'(irq), 0);
    end
    reg_addr = 3'd0;
    #1;
    chk("post_rst_pend", reg_rdata, 0);
    reg_addr = 3'd4;
    #1;
    chk("post_rst_claim", reg_rdata, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irq_prio_ctrl.md
Name: irq_prio_ctrl

Overview:
- Interrupt source arbiter directly upstream of the core's interrupt-injection sequencer.
- Synchronises and edge-detects up to NUM_SRC external interrupt lines and latches them as pending.
- Picks the highest-priority enabled pending source, holds a level `irq` request until the sequencer returns `irq_ack`, and tracks nested active priorities on a small stack that pops on `eret_ack`.
- Software reaches it through a word-addressed peripheral register port.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..8).
- PRIO_W, 3, priority width; priority 0 means "never interrupts".
- NEST_DEPTH, 4, maximum interrupt nesting depth (active-priority stack entries).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- src_irq  input  NUM_SRC  raw asynchronous interrupt lines, rising-edge sensitive.
- irq  output  1  registered request to the injection sequencer.
- irq_ack  input  1  one-cycle pulse; sequencer has committed to ISR entry.
- eret_ack  input  1  one-cycle pulse; sequencer has completed the return sequence.
- reg_we  input  1  register write strobe.
- reg_addr  input  3  word offset.
- reg_wdata  input  32  write data.
- reg_rdata  output  32  combinational read data.
- claim_id  output  4  {valid, id[2:0]} of the top-of-stack active source.
- nest_err  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous): all of the following clear immediately, with no clock needed. Pending, enable, priorities, threshold, stack, irq=0, claim_id=0, nest_err=0, FSM=IDLE.
- Input path: each src_irq bit passes through a 2-flop synchroniser and then an edge register. edge = sync2 & ~prev.
- Pending capture: a pending bit sets on the clock after its edge is detected. Source first sampled high at edge N gives pending=1 after edge N+2.
- Pending is latched regardless of the enable bit.
- If a W1C clear and a new edge hit the same bit in the same cycle, the edge wins and the bit stays pending.
- Eligibility: a source is eligible when pending & enable & prio > max(threshold, active_prio). active_prio is the top of the stack, or 0 when the stack is empty.
- Winner selection: highest prio among eligible sources; on a tie, the lowest index wins.
- FSM IDLE: if an eligible source exists and the stack is not full, latch win_id/win_prio, set irq=1 and go to REQ. An eligible source at edge N gives irq=1 after edge N.
- FSM REQ: irq held at 1; win_id is frozen, so sources becoming eligible later do not retarget the request.
  - On irq_ack: clear pending[win_id], push win_prio and win_id, irq=0, go to IDLE.
  - The next request is evaluated no earlier than the following cycle.
- Software clear during REQ: if pending[win_id] is cleared by software while in REQ, the request is not withdrawn. irq stays high until irq_ack and the push still occurs.
- eret_ack: pops the stack, valid in either state.
  - eret_ack with an empty stack: ignored, and nest_err is set.
  - irq_ack and eret_ack in the same cycle: pop then push, so net depth is unchanged.
- Stack full (depth = NEST_DEPTH): no new request. irq_ack arriving in IDLE sets nest_err and is otherwise ignored.
- claim_id: {1, top id}, or 0 when the stack is empty.
- Register map (word offsets):
  - 0 PENDING: read; write 1 to clear.
  - 1 ENABLE: RW, bits [NUM_SRC-1:0].
  - 2 PRIO: RW, nibble i holds [PRIO_W-1:0] of source i; the upper nibble bit reads 0.
  - 3 THRESHOLD: RW, bits [PRIO_W-1:0].
  - 4 CLAIM: read, {28'b0, claim_id}.
  - 5 STATUS: read, {nest_err, depth}. Writing bit31 = 1 clears nest_err.
  - Others: read 0, writes ignored.
- Register writes take effect after the clock edge. Reads are combinational from the current register state.

Test Plan:
- Single source: ENABLE=0x01, PRIO[0]=3, pulse src_irq[0] at edge 0 → PENDING=0x01 after edge 2, irq=1 after edge 3. irq_ack → irq=0, PENDING=0, claim_id=0x8.
- Priority and tie: PRIO src2=5, src5=5, src6=2, all three edges on the same cycle → win_id=2. After irq_ack, src5 does not request (5 not > active 5) until eret_ack; then it requests.
- Nesting: active prio 2 (src6). Src1 with prio 7 edges → irq re-asserts and is acked, depth=2, claim_id=0x9. Two eret_acks → depth=0, claim_id=0.
- Freeze in REQ: in REQ for src3 (prio 2), src4 (prio 6) edges → irq stays high; irq_ack pushes id 3. The next request is id 4.
- Boundaries: eret_ack with empty stack → nest_err=1, depth stays 0; write STATUS bit31 → nest_err=0. W1C PENDING bit 0 in the same cycle as a src0 edge → bit remains 1.
- Async reset: drop rst in REQ mid-cycle → irq=0 and all registers 0 before the next clk edge. After release, no request occurs without new edges.
